wb_regfile: RTL and testbench

- Writeback-side consumer of the MEM/WB pipeline register outputs.
- Qualifies each retiring instruction's register write, including conditional moves gated by the zero flag.
- Commits the write into a 32-entry general-purpose register file and serves two combinational read ports to the decode stage.
- Keeps retirement statistics counters.

---
 rtl/wb_regfile.sv | 102 ++++++++++
 tb/tb_wb_regfile.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// Writeback register file: qualifies MEM/WB writes, commits them, serves two reads.
// Optional write-through read bypass under `WB_REGFILE_BYPASS_EN.
module wb_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  WB_RegWrite,
  input  logic                  WB_CondMov,
  input  logic                  WB_ZeroFlag,
  input  logic [DATA_WIDTH-1:0] WB_ALUResult,
  input  logic [ADDR_WIDTH-1:0] WB_WriteRegister,
  input  logic [ADDR_WIDTH-1:0] ReadRegister1,
  input  logic [ADDR_WIDTH-1:0] ReadRegister2,
  output logic [DATA_WIDTH-1:0] ReadData1,
  output logic [DATA_WIDTH-1:0] ReadData2,
  output logic                  CommitValid,
  output logic [ADDR_WIDTH-1:0] CommitRegister,
  output logic [DATA_WIDTH-1:0] CommitData,
  output logic [CNT_WIDTH-1:0]  WriteCount,
  output logic [CNT_WIDTH-1:0]  SuppressCount
);

  localparam int NREG = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [NREG];
  logic                  we;
  logic                  sup;
  logic                  wc_sat;
  logic                  sc_sat;

  assign we = WB_RegWrite
            & (~WB_CondMov | WB_ZeroFlag)
            & (WB_WriteRegister != '0);

  // Suppressed cond-moves count even when aimed at r0.
  assign sup = WB_RegWrite & WB_CondMov & ~WB_ZeroFlag;

  assign wc_sat = &WriteCount;
  assign sc_sat = &SuppressCount;

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[WB_WriteRegister] <= WB_ALUResult;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      CommitValid    <= 1'b0;
      CommitRegister <= '0;
      CommitData     <= '0;
    end else begin
      CommitValid <= we;
      if (we) begin
        CommitRegister <= WB_WriteRegister;
        CommitData     <= WB_ALUResult;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      WriteCount    <= '0;
      SuppressCount <= '0;
    end else begin
      if (we && !wc_sat) begin
        WriteCount <= WriteCount + CNT_WIDTH'(1);
      end
      if (sup && !sc_sat) begin
        SuppressCount <= SuppressCount + CNT_WIDTH'(1);
      end
    end
  end

  always_comb begin
    ReadData1 = '0;
    ReadData2 = '0;
    if (ReadRegister1 != '0) begin
      ReadData1 = regs[ReadRegister1];
    end
    if (ReadRegister2 != '0) begin
      ReadData2 = regs[ReadRegister2];
    end
`ifdef WB_REGFILE_BYPASS_EN
    // we already excludes r0 and suppressed moves.
    if (we && ReadRegister1 == WB_WriteRegister) begin
      ReadData1 = WB_ALUResult;
    end
    if (we && ReadRegister2 == WB_WriteRegister) begin
      ReadData2 = WB_ALUResult;
    end
`endif
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed steps, random traffic,
// mid-stream reset and counter saturation against a reference model.
module tb_wb_regfile;

  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int CW   = 16;
  localparam int N    = 32;
  localparam int CMAX = (1 << CW) - 1;

  logic          Clk = 1'b0;
  logic          Rst_n;
  logic          WB_RegWrite;
  logic          WB_CondMov;
  logic          WB_ZeroFlag;
  logic [DW-1:0] WB_ALUResult;
  logic [AW-1:0] WB_WriteRegister;
  logic [AW-1:0] ReadRegister1;
  logic [AW-1:0] ReadRegister2;
  logic [DW-1:0] ReadData1;
  logic [DW-1:0] ReadData2;
  logic          CommitValid;
  logic [AW-1:0] CommitRegister;
  logic [DW-1:0] CommitData;
  logic [CW-1:0] WriteCount;
  logic [CW-1:0] SuppressCount;

  always #5 Clk = ~Clk;

  wb_regfile #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .CNT_WIDTH (CW)
  ) dut (
    .Clk             (Clk),
    .Rst_n           (Rst_n),
    .WB_RegWrite     (WB_RegWrite),
    .WB_CondMov      (WB_CondMov),
    .WB_ZeroFlag     (WB_ZeroFlag),
    .WB_ALUResult    (WB_ALUResult),
    .WB_WriteRegister(WB_WriteRegister),
    .ReadRegister1   (ReadRegister1),
    .ReadRegister2   (ReadRegister2),
    .ReadData1       (ReadData1),
    .ReadData2       (ReadData2),
    .CommitValid     (CommitValid),
    .CommitRegister  (CommitRegister),
    .CommitData      (CommitData),
    .WriteCount      (WriteCount),
    .SuppressCount   (SuppressCount)
  );

  logic [DW-1:0] model [N];
  int unsigned   wcnt;
  int unsigned   scnt;
  logic          cv;
  logic [AW-1:0] creg;
  logic [DW-1:0] cdat;
  int            n_checks = 0;
  int            n_fail   = 0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit model_we();
    if (!WB_RegWrite) return 1'b0;
    if (WB_CondMov && !WB_ZeroFlag) return 1'b0;
    return WB_WriteRegister != 0;
  endfunction

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] idx);
    if (idx == 0) return '0;
`ifdef WB_REGFILE_BYPASS_EN
    if (model_we() && idx == WB_WriteRegister) return WB_ALUResult;
`endif
    return model[idx];
  endfunction

  task automatic check_state(input string tag);
    check({tag, "_cv"},   {31'd0, CommitValid}, {31'd0, cv});
    check({tag, "_creg"}, {27'd0, CommitRegister}, {27'd0, creg});
    check({tag, "_cdat"}, CommitData, cdat);
    check({tag, "_wcnt"}, {16'd0, WriteCount}, wcnt);
    check({tag, "_scnt"}, {16'd0, SuppressCount}, scnt);
  endtask

  task automatic step(input logic rw, input logic cm,
                      input logic zf, input logic [DW-1:0] d,
                      input logic [AW-1:0] dst,
                      input logic [AW-1:0] r1,
                      input logic [AW-1:0] r2,
                      input bit chk);
    bit we;
    bit sup;
    @(negedge Clk);
    WB_RegWrite      = rw;
    WB_CondMov       = cm;
    WB_ZeroFlag      = zf;
    WB_ALUResult     = d;
    WB_WriteRegister = dst;
    ReadRegister1    = r1;
    ReadRegister2    = r2;
    #1;
    if (chk) begin
      check("rd1_pre", ReadData1, exp_rd(r1));
      check("rd2_pre", ReadData2, exp_rd(r2));
    end
    we  = model_we();
    sup = rw && cm && !zf;
    @(posedge Clk);
    if (we) begin
      model[dst] = d;
      cv   = 1'b1;
      creg = dst;
      cdat = d;
      if (wcnt < CMAX) wcnt++;
    end else begin
      cv = 1'b0;
    end
    if (sup && scnt < CMAX) scnt++;
    #1;
    if (chk) begin
      check("rd1_post", ReadData1, exp_rd(r1));
      check("rd2_post", ReadData2, exp_rd(r2));
      check_state("step");
    end
  endtask

  // Reset edge with a write in flight; the write must be discarded.
  task automatic do_reset();
    @(negedge Clk);
    Rst_n            = 1'b0;
    WB_RegWrite      = 1'b1;
    WB_CondMov       = 1'b0;
    WB_ZeroFlag      = 1'b0;
    WB_ALUResult     = 32'h55;
    WB_WriteRegister = 5'd4;
    @(posedge Clk);
    for (int i = 0; i < N; i++) model[i] = '0;
    wcnt = 0;
    scnt = 0;
    cv   = 1'b0;
    creg = '0;
    cdat = '0;
    #1;
    check_state("rst");
    WB_RegWrite = 1'b0;
    for (int i = 0; i < N; i++) begin
      ReadRegister1 = AW'(i);
      ReadRegister2 = AW'(N - 1 - i);
      #1;
      check("rst_rd1", ReadData1, 32'd0);
      check("rst_rd2", ReadData2, 32'd0);
    end
    @(negedge Clk);
    Rst_n = 1'b1;
  endtask

  initial begin
    Rst_n            = 1'b0;
    WB_RegWrite      = 1'b0;
    WB_CondMov       = 1'b0;
    WB_ZeroFlag      = 1'b0;
    WB_ALUResult     = '0;
    WB_WriteRegister = '0;
    ReadRegister1    = '0;
    ReadRegister2    = '0;
    for (int i = 0; i < N; i++) model[i] = '0;
    wcnt = 0;
    scnt = 0;
    cv   = 1'b0;
    creg = '0;
    cdat = '0;

    do_reset();

    step(1, 0, 0, 32'hDEADBEEF, 5, 5, 0, 1);
    check("dir_rd5", ReadData1, 32'hDEADBEEF);
    check("dir_wc1", {16'd0, WriteCount}, 32'd1);

    step(1, 1, 0, 32'h1234, 7, 7, 5, 1);
    check("cm_sup_rd7", ReadData1, 32'd0);
    check("cm_sup_sc", {16'd0, SuppressCount}, 32'd1);
    step(1, 1, 1, 32'h1234, 7, 7, 5, 1);
    check("cm_ok_rd7", ReadData1, 32'h1234);
    check("cm_ok_wc", {16'd0, WriteCount}, 32'd2);

    step(1, 0, 0, 32'hFFFFFFFF, 0, 5, 0, 1);
    check("r0_rd", ReadData2, 32'd0);
    check("r0_cv", {31'd0, CommitValid}, 32'd0);

    step(1, 0, 0, 32'h11, 9, 9, 9, 1);
    step(1, 0, 0, 32'hA5A5A5A5, 9, 9, 0, 1);
    check("byp_after", ReadData1, 32'hA5A5A5A5);

    step(0, 1, 1, 32'h777, 3, 3, 9, 1);
    step(1, 1, 0, 32'h888, 0, 0, 9, 1);

    for (int k = 0; k < 400; k++) begin
      step($urandom_range(1) == 1,
           $urandom_range(3) == 0,
           $urandom_range(1) == 1,
           $urandom,
           AW'($urandom_range(N - 1)),
           AW'($urandom_range(N - 1)),
           AW'($urandom_range(N - 1)),
           1);
    end

    step(1, 0, 0, 32'h1, 1, 1, 2, 1);
    step(1, 0, 0, 32'h2, 2, 1, 2, 1);
    step(1, 0, 0, 32'h3, 3, 3, 4, 1);
    do_reset();

    for (int k = 0; k < (1 << CW) + 2; k++) begin
      step(1, 0, 0, $urandom, AW'($urandom_range(N - 1, 1)),
           0, 0, 0);
    end
    step(1, 0, 0, 32'hCAFEF00D, 12, 12, 3, 1);
    check("sat_wc", {16'd0, WriteCount}, 32'h0000FFFF);
    step(1, 1, 0, 32'h0, 6, 12, 6, 1);
    check("sat_hold", {16'd0, WriteCount}, 32'h0000FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
